// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding, default sizes and length-width helper for seq_detect_ctrl
package seq_detect_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_WIN_W = 16;
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/seq_shift_matcher.sv
// seq_shift_matcher: serial history shift register with a length-masked pattern comparator
//   clk, rst   clock and synchronous active-high reset
//   clr        clear the history
//   en         shift din into bit 0
//   din        serial bit
//   pattern    target pattern, bit len-1 is the oldest bit
//   len        active pattern length
//   hit        combinational: the history after this shift matches the pattern
module seq_shift_matcher #(
    parameter int MAX_LEN = 8,
    parameter int LW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    output logic               hit
);
    // The oldest stored bit falls off on every shift, so only MAX_LEN-1 bits need storage
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] shifted, mask;
    assign shifted = {hist_q, din};
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_mask
        assign mask[g] = len > LW'(g);
    end
    assign hit = ((shifted ^ pattern) & mask) == '0;
    always_comb begin
        hist_d = clr ? '0 : en ? shifted[MAX_LEN-2:0] : hist_q;
    end
    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else hist_q <= hist_d;
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial bit-pattern detector controller with match threshold and window
//   CLK, RST             clock, synchronous active-high reset
//   CFG_WE, CFG_*        shadow config write (IDLE only): pattern, length, threshold, window
//   START, ABORT         begin / terminate a detection run
//   IN, IN_VALID         serial data and its qualifier
//   MATCH, DONE, TIMEOUT one-cycle pulses; MATCH_CNT saturating match count; BUSY in FILL/RUN
//   Define SEQ_DETECT_CTRL_TIMEOUT_EN to build the observation-window counter and TIMEOUT.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CFG_WE,
    input  logic [MAX_LEN-1:0]          CFG_PATTERN,
    input  logic [len_w(MAX_LEN)-1:0]   CFG_LEN,
    input  logic [CNT_W-1:0]            CFG_THRESH,
    input  logic [WIN_W-1:0]            CFG_WINDOW,
    input  logic                        START,
    input  logic                        ABORT,
    input  logic                        IN,
    input  logic                        IN_VALID,
    output logic                        MATCH,
    output logic [CNT_W-1:0]            MATCH_CNT,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        TIMEOUT
);
    localparam int LW = len_w(MAX_LEN);
    state_e state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0] len_q, len_d, fill_q, fill_d;
    logic [CNT_W-1:0] thresh_q, thresh_d, cnt_q, cnt_d;
    logic match_q, match_d, done_q, done_d, timeout_q, timeout_d, busy_q, busy_d;
    logic len_ok, go, last_fill, compare, hit, expire;
    assign len_ok = len_q != '0 && len_q <= LW'(MAX_LEN);
    assign go = state_q == IDLE && START && !ABORT && len_ok;
    assign last_fill = fill_q == len_q - LW'(1);
    // The LEN-th valid bit in FILL is compared in the same cycle it completes the history
    assign compare = IN_VALID && (state_q == RUN || (state_q == FILL && last_fill));
    seq_shift_matcher #(.MAX_LEN(MAX_LEN), .LW(LW)) u_matcher (
        .clk(CLK),
        .rst(RST),
        .clr(go),
        .en(IN_VALID && state_q != IDLE && !ABORT),
        .din(IN),
        .pattern(pat_q),
        .len(len_q),
        .hit(hit)
    );
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic [WIN_W-1:0] window_q, window_d, win_q, win_d;
    assign expire = state_q != IDLE && win_q == WIN_W'(1);
    always_comb begin
        window_d = (state_q == IDLE && CFG_WE) ? CFG_WINDOW : window_q;
        win_d = (state_q == IDLE) ? (go ? window_q : win_q) : (win_q != '0 ? win_q - WIN_W'(1) : win_q);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            window_q <= '0;
            win_q <= '0;
        end else begin
            window_q <= window_d;
            win_q <= win_d;
        end
    end
`else
    logic unused_window;
    assign unused_window = ^CFG_WINDOW;
    assign expire = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pat_d = pat_q;
        len_d = len_q;
        thresh_d = thresh_q;
        fill_d = fill_q;
        cnt_d = cnt_q;
        match_d = 1'b0;
        done_d = 1'b0;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (CFG_WE) begin
                pat_d = CFG_PATTERN;
                len_d = CFG_LEN;
                thresh_d = CFG_THRESH;
            end
            if (go) begin
                state_d = FILL;
                fill_d = '0;
                cnt_d = '0;
            end
        end else if (ABORT) begin
            state_d = IDLE;
        end else begin
            if (IN_VALID && state_q == FILL) begin
                fill_d = fill_q + LW'(1);
                state_d = last_fill ? RUN : FILL;
            end
            if (compare && hit) begin
                match_d = 1'b1;
                cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                if (thresh_q != '0 && cnt_d == thresh_q) begin
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            if (expire && !done_d) begin
                timeout_d = 1'b1;
                state_d = IDLE;
            end
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pat_q <= '0;
            len_q <= '0;
            thresh_q <= '0;
            fill_q <= '0;
            cnt_q <= '0;
            match_q <= 1'b0;
            done_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q <= pat_d;
            len_q <= len_d;
            thresh_q <= thresh_d;
            fill_q <= fill_d;
            cnt_q <= cnt_d;
            match_q <= match_d;
            done_q <= done_d;
            timeout_q <= timeout_d;
            busy_q <= busy_d;
        end
    end
    assign MATCH = match_q;
    assign MATCH_CNT = cnt_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign TIMEOUT = timeout_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic rst, cfg_we, start, abort, in_bit, in_valid;
    logic [7:0] cfg_pattern, cfg_thresh;
    logic [3:0] cfg_len;
    logic [15:0] cfg_window;
    logic match, busy, done, timeout;
    logic [7:0] match_cnt;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    seq_detect_ctrl dut (
        .CLK(clk),
        .RST(rst),
        .CFG_WE(cfg_we),
        .CFG_PATTERN(cfg_pattern),
        .CFG_LEN(cfg_len),
        .CFG_THRESH(cfg_thresh),
        .CFG_WINDOW(cfg_window),
        .START(start),
        .ABORT(abort),
        .IN(in_bit),
        .IN_VALID(in_valid),
        .MATCH(match),
        .MATCH_CNT(match_cnt),
        .BUSY(busy),
        .DONE(done),
        .TIMEOUT(timeout)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t, input logic [15:0] w);
        cfg_pattern = p;
        cfg_len = l;
        cfg_thresh = t;
        cfg_window = w;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask
    task automatic go;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic bit_in(input logic b, input logic v);
        in_bit = b;
        in_valid = v;
        tick();
        in_valid = 1'b0;
    endtask
    task automatic stop;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask
    initial begin
        logic [6:0] s1, m1, s4, v4, m4;
        logic [4:0] s2, m2, d2;
        s1 = 7'b1001001;
        m1 = 7'b0001001;
        s2 = 5'b10101;
        m2 = 5'b00101;
        d2 = 5'b00001;
        s4 = 7'b1001101;
        v4 = 7'b1010101;
        m4 = 7'b0000001;
        {rst, cfg_we, start, abort, in_bit, in_valid} = '0;
        {cfg_pattern, cfg_thresh, cfg_len, cfg_window} = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out", {match, done, timeout, busy, match_cnt}, 0);
        // overlapping 1001 on 1001001, no threshold
        cfg(8'b1001, 4'd4, 8'd0, 16'd0);
        go();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 7; i++) begin
            bit_in(s1[6-i], 1'b1);
            chk("t1_match", match, m1[6-i]);
        end
        chk("t1_cnt", match_cnt, 2);
        chk("t1_busy_end", busy, 1);
        stop();
        chk("t1_abort_busy", busy, 0);
        chk("t1_abort_cnt", match_cnt, 2);
        // threshold 2 with pattern 101 on 10101
        cfg(8'b101, 4'd3, 8'd2, 16'd0);
        go();
        for (int i = 0; i < 5; i++) begin
            bit_in(s2[4-i], 1'b1);
            chk("t2_match", match, m2[4-i]);
            chk("t2_done", done, d2[4-i]);
        end
        chk("t2_busy", busy, 0);
        chk("t2_cnt", match_cnt, 2);
        // window expiry with no matches
        cfg(8'b1111, 4'd4, 8'd0, 16'd5);
        go();
        for (int i = 1; i <= 5; i++) begin
            bit_in(1'b0, 1'b1);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            chk("t3_timeout", timeout, i == 5);
            chk("t3_busy", busy, i < 5);
`else
            chk("t3_timeout", timeout, 0);
            chk("t3_busy", busy, 1);
`endif
        end
        bit_in(1'b0, 1'b1);
        chk("t3_timeout_once", timeout, 0);
        if (busy) stop();
        // match on the window's last cycle: DONE wins over TIMEOUT
        cfg(8'b0001, 4'd4, 8'd1, 16'd5);
        go();
        for (int i = 0; i < 4; i++) bit_in(i == 0, 1'b1);
        chk("t3b_no_match", match, 0);
        bit_in(1'b1, 1'b1);
        chk("t3b_match", match, 1);
        chk("t3b_done", done, 1);
        chk("t3b_timeout", timeout, 0);
        chk("t3b_busy", busy, 0);
        chk("t3b_cnt", match_cnt, 1);
        // invalid bits must not shift
        cfg(8'b1011, 4'd4, 8'd0, 16'd0);
        go();
        for (int i = 0; i < 7; i++) begin
            bit_in(s4[6-i], v4[6-i]);
            chk("t4_match", match, m4[6-i]);
        end
        stop();
        // abort after one match, config write during run ignored
        cfg(8'b11, 4'd2, 8'd5, 16'd0);
        go();
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b1);
        chk("t5_match", match, 1);
        cfg(8'b00, 4'd0, 8'd1, 16'd0);
        in_bit = 1'b1;
        in_valid = 1'b1;
        stop();
        in_valid = 1'b0;
        chk("t5_abort_match", match, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_cnt", match_cnt, 1);
        go();
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_cnt", match_cnt, 0);
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b1);
        chk("t5_cfg_kept", match, 1);
        stop();
        // saturating count
        cfg(8'b11, 4'd2, 8'd0, 16'd0);
        go();
        for (int i = 0; i < 260; i++) bit_in(1'b1, 1'b1);
        chk("sat_cnt", match_cnt, 255);
        chk("sat_match", match, 1);
        stop();
        // invalid lengths and START+ABORT in IDLE
        cfg(8'b1, 4'd0, 8'd0, 16'd0);
        go();
        chk("len0_busy", busy, 0);
        cfg(8'b1, 4'd9, 8'd0, 16'd0);
        go();
        chk("len9_busy", busy, 0);
        cfg(8'b101, 4'd3, 8'd0, 16'd0);
        abort = 1'b1;
        go();
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        // reset mid-FILL clears outputs and shadow config
        go();
        bit_in(1'b1, 1'b1);
        chk("t6_fill_busy", busy, 1);
        rst = 1'b1;
        bit_in(1'b0, 1'b1);
        rst = 1'b0;
        chk("t6_rst_out", {match, done, timeout, busy, match_cnt}, 0);
        go();
        chk("t6_cfg_cleared", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
